mips_mc_ctrl: RTL and testbench

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

---
 rtl/mips_mc_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/execute-phase sequencer with
// combinational strobes, sticky illegal-opcode HALT and a saturating retire counter.
module mips_mc_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero_bit,
  output logic [3:0]       state,
  output logic             ir_write,
  output logic             pc_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             byte_en,
  output logic             reg_write,
  output logic             retire,
  output logic             illegal,
  output logic [1:0]       pc_src,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_src,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctr,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_ACC  = 4'd5,
    S_WB       = 4'd6,
    S_BRANCH   = 4'd7,
    S_JUMP     = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    K_ILL, K_RALU, K_IALU, K_MOVE, K_LW, K_LB, K_SW, K_SB,
    K_BEQ, K_BNE, K_J, K_JAL, K_JR
  } kind_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  kind_t            kind;
  logic [2:0]       alu_sel;
  logic             is_load, is_store, is_byte;
  state_t           bnd_state;

  // R-type funct and I-type opcode share the same ALU operation encodings.
  function automatic logic [2:0] alu_code(input logic [5:0] c);
    case (c)
      6'b000011: alu_code = 3'd1;
      6'b000100: alu_code = 3'd2;
      6'b000101: alu_code = 3'd3;
      6'b000111: alu_code = 3'd4;
      default:   alu_code = 3'd0;
    endcase
  endfunction

  // Instruction class decode from the instruction-register fields.
  always_comb begin
    kind    = K_ILL;
    alu_sel = 3'd0;
    case (opcode)
      6'b000000: begin
        alu_sel = alu_code(funct);
        case (funct)
          6'b000010, 6'b000011, 6'b000100,
          6'b000101, 6'b000111: kind = K_RALU;
          6'b001000:            kind = K_JR;
          default:              kind = K_ILL;
        endcase
      end
      6'b000010, 6'b000011, 6'b000100,
      6'b000101, 6'b000111: begin
        kind    = K_IALU;
        alu_sel = alu_code(opcode);
      end
      6'b001000: kind = K_LW;
      6'b001001: kind = K_LB;
      6'b010000: kind = K_SW;
      6'b010001: kind = K_SB;
      6'b100011: kind = K_BEQ;
      6'b100111: kind = K_BNE;
      6'b111000: kind = K_J;
      6'b111001: kind = K_JAL;
      6'b100000: kind = K_MOVE;
      default:   kind = K_ILL;
    endcase
  end

  assign is_load   = (kind == K_LW) || (kind == K_LB);
  assign is_store  = (kind == K_SW) || (kind == K_SB);
  assign is_byte   = (kind == K_LB) || (kind == K_SB);
  assign bnd_state = run ? S_FETCH : S_IDLE;

  // Next-state and strobe generation.
  always_comb begin
    state_d   = state_q;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    byte_en   = 1'b0;
    reg_write = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;
    pc_src    = 2'd0;
    reg_dst   = 2'd0;
    wb_src    = 2'd0;
    alu_src_b = 2'd0;
    alu_ctr   = 3'd0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'd2;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        case (kind)
          K_ILL:                        state_d = S_HALT;
          K_RALU, K_IALU, K_MOVE:       state_d = S_EXEC;
          K_LW, K_LB, K_SW, K_SB:       state_d = S_MEM_ADDR;
          K_BEQ, K_BNE:                 state_d = S_BRANCH;
          default:                      state_d = S_JUMP;
        endcase
      end
      S_EXEC: begin
        alu_src_b = (kind == K_RALU) ? 2'd0 : 2'd1;
        alu_ctr   = (kind == K_MOVE) ? 3'd5 : alu_sel;
        state_d   = S_WB;
      end
      S_MEM_ADDR: begin
        alu_src_b = 2'd1;
        state_d   = S_MEM_ACC;
      end
      S_MEM_ACC: begin
        byte_en = is_byte;
        if (is_store) begin
          mem_write = 1'b1;
          retire    = 1'b1;
          state_d   = bnd_state;
        end else begin
          mem_read = 1'b1;
          state_d  = S_WB;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = (kind == K_RALU) ? 2'd1 : 2'd0;
        wb_src    = is_load ? 2'd1 : 2'd0;
        byte_en   = is_byte;
        retire    = 1'b1;
        state_d   = bnd_state;
      end
      S_BRANCH: begin
        alu_ctr  = 3'd1;
        pc_src   = 2'd1;
        pc_write = ((kind == K_BEQ) && zero_bit) || ((kind == K_BNE) && !zero_bit);
        retire   = 1'b1;
        state_d  = bnd_state;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = (kind == K_JR) ? 2'd3 : 2'd2;
        retire   = 1'b1;
        if (kind == K_JAL) begin
          reg_write = 1'b1;
          reg_dst   = 2'd2;
          wb_src    = 2'd2;
        end
        state_d = bnd_state;
      end
      S_HALT:  illegal = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // Nothing may be committed in a reset cycle, whatever state was reached.
    if (reset) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      byte_en   = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
      illegal   = 1'b0;
      pc_src    = 2'd0;
      reg_dst   = 2'd0;
      wb_src    = 2'd0;
      alu_src_b = 2'd0;
      alu_ctr   = 3'd0;
    end
  end

  // Retired-instruction counter, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (retire && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: per-instruction expected cycle records
// queued by the driver, compared on every falling edge, plus literal spot checks.
module tb_mips_mc_ctrl;

  localparam int unsigned CW = 3;

  localparam int K_R = 0, K_I = 1, K_MV = 2, K_LW = 3, K_LB = 4, K_SW = 5, K_SB = 6;
  localparam int K_BEQ = 7, K_BNE = 8, K_J = 9, K_JAL = 10, K_JR = 11;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic [5:0]    opcode = 6'd0;
  logic [5:0]    funct = 6'd0;
  logic          zero_bit = 1'b0;
  logic [3:0]    state;
  logic          ir_write, pc_write, mem_read, mem_write, byte_en, reg_write, retire, illegal;
  logic [1:0]    pc_src, reg_dst, wb_src, alu_src_b;
  logic [2:0]    alu_ctr;
  logic [CW-1:0] instr_count;

  mips_mc_ctrl #(.CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
    .zero_bit(zero_bit), .state(state), .ir_write(ir_write), .pc_write(pc_write),
    .mem_read(mem_read), .mem_write(mem_write), .byte_en(byte_en),
    .reg_write(reg_write), .retire(retire), .illegal(illegal), .pc_src(pc_src),
    .reg_dst(reg_dst), .wb_src(wb_src), .alu_src_b(alu_src_b), .alu_ctr(alu_ctr),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         id;
    logic [3:0] st;
    logic       ir_write, pc_write, mem_read, mem_write, byte_en, reg_write, retire, illegal;
    logic [1:0] pc_src, reg_dst, wb_src, alu_src_b;
    logic [2:0] alu_ctr;
    logic [2:0] cnt;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zb;
    int         k;
    logic [2:0] alu;
    logic       mid_run;
    logic       run_end;
    int         lit_cnt;
    int         lit_lat;
  } vec_t;

  exp_t q[$];
  exp_t ce;
  int   errors = 0;
  int   checks = 0;
  int   rec_id = 0;
  int   m_cnt  = 0;
  vec_t vecs[11];

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s rec=%0d actual=%0h expected=%0h", nm, id, act, exp);
    end
  endtask

  function automatic int lat(input int k);
    case (k)
      K_R, K_I, K_MV:   lat = 4;
      K_LW, K_LB:       lat = 5;
      K_SW, K_SB:       lat = 4;
      default:          lat = 3;
    endcase
  endfunction

  function automatic exp_t zero_rec(input logic [3:0] st, input int cnt);
    exp_t e;
    e = '{default: '0};
    e.st  = st;
    e.cnt = 3'(cnt);
    return e;
  endfunction

  // Expected outputs of step s of an instruction, written from the per-phase rules.
  function automatic exp_t exp_step(input vec_t v, input int s, input int cnt);
    exp_t e;
    logic byte_op, load_op;
    byte_op = (v.k == K_LB) || (v.k == K_SB);
    load_op = (v.k == K_LW) || (v.k == K_LB);
    e = zero_rec(4'd0, cnt);
    if (s == 0) begin
      e.st = 4'd1; e.mem_read = 1; e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'd2;
    end else if (s == 1) begin
      e.st = 4'd2;
    end else if (v.k == K_R || v.k == K_I || v.k == K_MV) begin
      if (s == 2) begin
        e.st = 4'd3; e.alu_src_b = (v.k == K_R) ? 2'd0 : 2'd1; e.alu_ctr = v.alu;
      end else begin
        e.st = 4'd6; e.reg_write = 1; e.retire = 1; e.reg_dst = (v.k == K_R) ? 2'd1 : 2'd0;
      end
    end else if (load_op || v.k == K_SW || v.k == K_SB) begin
      if (s == 2) begin
        e.st = 4'd4; e.alu_src_b = 2'd1;
      end else if (s == 3) begin
        e.st = 4'd5; e.byte_en = byte_op;
        if (load_op) e.mem_read = 1;
        else begin e.mem_write = 1; e.retire = 1; end
      end else begin
        e.st = 4'd6; e.reg_write = 1; e.wb_src = 2'd1; e.retire = 1; e.byte_en = byte_op;
      end
    end else if (v.k == K_BEQ || v.k == K_BNE) begin
      e.st = 4'd7; e.alu_ctr = 3'd1; e.pc_src = 2'd1; e.retire = 1;
      e.pc_write = (v.k == K_BEQ) ? v.zb : !v.zb;
    end else begin
      e.st = 4'd8; e.pc_write = 1; e.retire = 1; e.pc_src = (v.k == K_JR) ? 2'd3 : 2'd2;
      if (v.k == K_JAL) begin e.reg_write = 1; e.reg_dst = 2'd2; e.wb_src = 2'd2; end
    end
    return e;
  endfunction

  task automatic push(input exp_t e);
    e.id = rec_id;
    rec_id++;
    q.push_back(e);
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle(input logic r);
    run = r;
    push(zero_rec(4'd0, m_cnt));
    @(negedge clock);
    adv();
  endtask

  task automatic run_instr(input vec_t v);
    int l;
    l = lat(v.k);
    for (int s = 0; s < l; s++) begin
      opcode   = v.op;
      funct    = v.fn;
      zero_bit = v.zb;
      run      = (s == l - 1) ? v.run_end : v.mid_run;
      push(exp_step(v, s, m_cnt));
      @(negedge clock);
      if (s == 0) chk("lit_cnt_at_fetch", s, 32'(instr_count), 32'(v.lit_cnt));
      if (s == v.lit_lat - 1) chk("lit_retire_at_latency", s, 32'(retire), 32'd1);
      adv();
    end
    if (m_cnt != 7) m_cnt++;
  endtask

  // Compare process: every queued cycle record is checked on the falling edge.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      ce = q.pop_front();
      chk("state",     ce.id, 32'(state),       32'(ce.st));
      chk("ir_write",  ce.id, 32'(ir_write),    32'(ce.ir_write));
      chk("pc_write",  ce.id, 32'(pc_write),    32'(ce.pc_write));
      chk("mem_read",  ce.id, 32'(mem_read),    32'(ce.mem_read));
      chk("mem_write", ce.id, 32'(mem_write),   32'(ce.mem_write));
      chk("byte_en",   ce.id, 32'(byte_en),     32'(ce.byte_en));
      chk("reg_write", ce.id, 32'(reg_write),   32'(ce.reg_write));
      chk("retire",    ce.id, 32'(retire),      32'(ce.retire));
      chk("illegal",   ce.id, 32'(illegal),     32'(ce.illegal));
      chk("pc_src",    ce.id, 32'(pc_src),      32'(ce.pc_src));
      chk("reg_dst",   ce.id, 32'(reg_dst),     32'(ce.reg_dst));
      chk("wb_src",    ce.id, 32'(wb_src),      32'(ce.wb_src));
      chk("alu_src_b", ce.id, 32'(alu_src_b),   32'(ce.alu_src_b));
      chk("alu_ctr",   ce.id, 32'(alu_ctr),     32'(ce.alu_ctr));
      chk("count",     ce.id, 32'(instr_count), 32'(ce.cnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{6'b000000, 6'b000010, 1'b0, K_R,   3'd0, 1'b1, 1'b1, 0, 4}; // ADD
    vecs[1]  = '{6'b001000, 6'b000000, 1'b0, K_LW,  3'd0, 1'b1, 1'b1, 1, 5}; // LW
    vecs[2]  = '{6'b010001, 6'b000000, 1'b0, K_SB,  3'd0, 1'b1, 1'b1, 2, 4}; // SB
    vecs[3]  = '{6'b100011, 6'b000000, 1'b1, K_BEQ, 3'd0, 1'b0, 1'b1, 3, 3}; // BEQ taken
    vecs[4]  = '{6'b100111, 6'b000000, 1'b1, K_BNE, 3'd0, 1'b1, 1'b1, 4, 3}; // BNE not taken
    vecs[5]  = '{6'b111001, 6'b000000, 1'b0, K_JAL, 3'd0, 1'b1, 1'b1, 5, 3}; // JAL
    vecs[6]  = '{6'b000000, 6'b001000, 1'b0, K_JR,  3'd0, 1'b1, 1'b1, 6, 3}; // JR
    vecs[7]  = '{6'b000000, 6'b000011, 1'b0, K_R,   3'd1, 1'b0, 1'b1, 7, 4}; // SUB, count saturates
    vecs[8]  = '{6'b000101, 6'b000000, 1'b0, K_I,   3'd3, 1'b1, 1'b1, 7, 4}; // ORI
    vecs[9]  = '{6'b100000, 6'b000000, 1'b0, K_MV,  3'd5, 1'b1, 1'b1, 7, 4}; // MOVE
    vecs[10] = '{6'b000111, 6'b000000, 1'b0, K_I,   3'd4, 1'b1, 1'b0, 7, 4}; // SLTI, then stop

    reset = 1'b1;
    adv();
    push(zero_rec(4'd0, 0));
    @(negedge clock);
    chk("lit_reset_state", 0, 32'(state), 32'd0);
    adv();
    reset = 1'b0;
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    for (int i = 0; i < 11; i++) run_instr(vecs[i]);
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    // Illegal opcode: DECODE -> HALT, sticky until reset.
    idle_cycle(1'b1);
    opcode = 6'b111111;
    funct  = 6'd0;
    push(exp_step(vecs[0], 0, m_cnt));
    @(negedge clock);
    adv();
    push(zero_rec(4'd2, m_cnt));
    @(negedge clock);
    adv();
    for (int i = 0; i < 4; i++) begin
      exp_t h;
      run = i[0];
      h = zero_rec(4'd9, m_cnt);
      h.illegal = 1'b1;
      push(h);
      @(negedge clock);
      chk("lit_halt_illegal", i, 32'(illegal), 32'd1);
      adv();
    end
    reset = 1'b1;
    push(zero_rec(4'd9, m_cnt));
    @(negedge clock);
    adv();
    reset = 1'b0;
    m_cnt = 0;
    idle_cycle(1'b0);
    chk("lit_cnt_after_reset", 0, 32'(instr_count), 32'd0);

    // Reset in MEM_ACC of SW aborts the store.
    idle_cycle(1'b1);
    run_instr(vecs[0]);
    begin
      vec_t sw;
      sw = '{6'b010000, 6'b000000, 1'b0, K_SW, 3'd0, 1'b1, 1'b1, 1, 4};
      for (int s = 0; s < 3; s++) begin
        opcode = sw.op;
        funct  = sw.fn;
        run    = 1'b1;
        push(exp_step(sw, s, m_cnt));
        @(negedge clock);
        adv();
      end
      reset = 1'b1;
      push(zero_rec(4'd5, m_cnt));
      @(negedge clock);
      chk("lit_reset_no_mem_write", 0, 32'(mem_write), 32'd0);
      adv();
      reset = 1'b0;
      run   = 1'b0;
      m_cnt = 0;
    end
    idle_cycle(1'b0);
    chk("lit_cnt_after_sw_reset", 0, 32'(instr_count), 32'd0);
    idle_cycle(1'b0);

    @(negedge clock);
    chk("queue_drained", 0, 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
